drift_comp_detect: RTL and testbench
====================================

Name: drift_comp_detect

Overview:
- Consumes the baseline estimate produced by the EMA drift tracker and the raw sample stream.
- Subtracts the baseline with saturation.
- Qualifies excursions of the corrected signal into discrete events (start/end/peak) using a threshold, hysteresis, minimum-length and holdoff state machine.
- Drives freeze_req so the tracker can be gated while an event is in progress.

Parameters:
- W, 24, sample / baseline / corrected width (signed)
- LEN_W, 8, width of min_len and the qualification counter
- HOLD_W, 16, width of holdoff and the holdoff counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- din  in  W  raw signed sample
- din_valid  in  1  sample strobe; all state advances only on strobed samples
- drift_in  in  W  signed baseline from tracker, sampled with din
- trig_th  in  W  unsigned trigger threshold
- rel_th  in  W  unsigned release threshold (hysteresis)
- min_len  in  LEN_W  consecutive over-threshold samples needed to declare an event; 0 treated as 1
- holdoff  in  HOLD_W  samples ignored after event end
- dout  out  W  corrected sample, sat(din - drift_in)
- dout_valid  out  1  registered din_valid
- sat_flag  out  1  dout was clipped, qualifies dout
- event_active  out  1  high while in EVENT
- event_start  out  1  one-cycle pulse
- event_end  out  1  one-cycle pulse
- peak_out  out  W  signed corrected sample with the largest magnitude in the event, valid with event_end
- freeze_req  out  1  high in CAND, EVENT, HOLDOFF

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous, active-low: the clock is clk, the reset is rst_n.
  - On reset, every output is 0 and the FSM is in IDLE.
  - Counters and the peak register are cleared on reset.
- Arithmetic:
  - diff = din - drift_in computed at W+1 bits.
  - If diff > 2^(W-1)-1, dout = 2^(W-1)-1 and sat_flag = 1.
  - If diff < -2^(W-1), dout = -2^(W-1) and sat_flag = 1.
  - mag = |corrected| as an unsigned W-bit value; -2^(W-1) gives 2^(W-1), no overflow.
- Latency:
  - dout, dout_valid and sat_flag update 1 cycle after din_valid.
  - The FSM evaluates the same combinational corrected sample on that edge.
  - Therefore event_start / event_end / peak_out align with the dout_valid of the deciding sample.
- Valid gating:
  - With din_valid = 0, the FSM, counters, peak and freeze_req hold their values.
  - Pulses and dout_valid go to 0.
- FSM (transitions only on valid samples; over = mag > trig_th strict; under = mag < rel_th strict):
  - IDLE:
    - If over, go to CAND, cnt = 1, peak = sample.
    - If additionally the effective min_len == 1, go directly to EVENT and pulse event_start.
  - CAND:
    - If over, cnt++ and update peak.
    - When cnt reaches min_len, go to EVENT and pulse event_start on that sample.
    - If not over, return to IDLE, clear cnt; no pulses.
  - EVENT:
    - Update peak when mag > |peak| (strictly greater; the first sample wins ties).
    - If under: pulse event_end, present peak_out, and go to HOLDOFF with hcnt = 0. If holdoff == 0, go to IDLE instead.
    - Samples with rel_th <= mag <= trig_th keep the FSM in EVENT.
  - HOLDOFF:
    - Triggers are ignored; hcnt++ on each valid sample.
    - When hcnt reaches holdoff, go to IDLE. The next valid sample after that is evaluated from IDLE.
- Outputs by state:
  - event_active = 1 in EVENT only; it rises with event_start and falls with event_end.
  - freeze_req = (state != IDLE), registered.
  - peak_out holds its last value between events.
- Boundary conditions:
  - If rel_th > trig_th, the release comparison still applies, so an event may end on the sample after it starts. This is legal.
  - Threshold inputs are sampled live on every valid; there is no shadowing.
  - Reset mid-event aborts the event with no event_end.
  - The counters saturate and never wrap (cnt stops at min_len, hcnt stops at holdoff).

Decomposition:
- Shared package drift_pkg:
  - default W
  - state encoding IDLE / CAND / EVENT / HOLDOFF
  - SAT_MAX / SAT_MIN constants
- One sub-module, sat_sub (combinational W+1-bit subtract with clip and flag), reusable by other baseline-correction paths.

Test Plan:
- Pass-through: din = 1000, drift_in = 400 -> next cycle dout = 600, dout_valid = 1, sat_flag = 0.
- Saturation (W = 24): din = 0x7FFFFF, drift_in = -10 -> dout = 0x7FFFFF, sat_flag = 1. din = 0x800000, drift_in = 5 -> dout = 0x800000, sat_flag = 1.
- Full event with trig_th = 100, rel_th = 50, min_len = 3, holdoff = 2:
  - Corrected 150, 160, 170 -> event_start and event_active with the 170 sample.
  - Then -300, 40 -> event_end on 40, peak_out = -300.
  - Then 200, 200 ignored (freeze_req = 1, no CAND); the third 200 enters CAND.
- Glitch rejection: corrected 150, 150, 20 with min_len = 3 -> no event_start, FSM back in IDLE, freeze_req drops after the 20.
- Valid gaps: the event sequence above with din_valid low for 5 cycles between samples -> identical pulse sequence, no counter advance during gaps.
- Reset mid-EVENT: assert rst_n = 0 asynchronously -> all outputs 0 immediately, no event_end. After release, a trigger needs a full min_len again.

Source files
------------

// File: rtl/drift_pkg.sv
// Shared types and constants for the baseline-correction / event-detection path.
package drift_pkg;

  localparam int DEF_W = 24;

  // Saturation limits of a DEF_W-bit signed value.
  localparam logic signed [DEF_W-1:0] SAT_MAX = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic signed [DEF_W-1:0] SAT_MIN = {1'b1, {(DEF_W-1){1'b0}}};

  // Event qualification states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAND    = 2'd1,
    EVENT   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

endpackage

// File: rtl/drift_comp_detect_if.sv
// Sample/baseline input stream and corrected/event output bundle.
interface drift_comp_detect_if #(
  parameter int W = 24
);
  logic signed [W-1:0] din;
  logic                din_valid;
  logic signed [W-1:0] drift_in;
  logic signed [W-1:0] dout;
  logic                dout_valid;
  logic                sat_flag;
  logic                event_active;
  logic                event_start;
  logic                event_end;
  logic signed [W-1:0] peak_out;
  logic                freeze_req;

  modport master (
    output din, din_valid, drift_in,
    input  dout, dout_valid, sat_flag, event_active, event_start, event_end,
           peak_out, freeze_req
  );

  modport slave (
    input  din, din_valid, drift_in,
    output dout, dout_valid, sat_flag, event_active, event_start, event_end,
           peak_out, freeze_req
  );
endinterface

// File: rtl/sat_sub.sv
// Combinational a - b at W+1 bits, clipped back to W bits with a clip flag.
module sat_sub
  import drift_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y,
  output logic                sat
);

  logic signed [W:0] diff;

  // Returns {clipped, value}; overflow shows as the two top bits disagreeing.
  function automatic logic [W:0] clip(input logic signed [W:0] d);
    logic [W:0] r;
    if (d[W] != d[W-1]) begin
      r = d[W] ? {1'b1, 1'b1, {(W-1){1'b0}}} : {1'b1, 1'b0, {(W-1){1'b1}}};
    end else begin
      r = {1'b0, d[W-1:0]};
    end
    return r;
  endfunction

  // Sign-extend both operands so the difference can never wrap.
  always_comb begin
    diff = {a[W-1], a} - {b[W-1], b};
    {sat, y} = clip(diff);
  end

endmodule

// File: rtl/drift_comp_detect.sv
// Baseline subtraction with saturation followed by a threshold / hysteresis /
// minimum-length / holdoff event qualifier. freeze_req gates the upstream
// drift tracker while an excursion is being qualified or is in progress.
module drift_comp_detect
  import drift_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int LEN_W  = 8,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  drift_comp_detect_if.slave bus,
  input  logic [W-1:0]      trig_th,
  input  logic [W-1:0]      rel_th,
  input  logic [LEN_W-1:0]  min_len,
  input  logic [HOLD_W-1:0] holdoff
);

  logic signed [W-1:0] corr;
  logic                corr_sat;
  logic [W-1:0]        mag;
  logic [W-1:0]        pk_mag;
  logic                over;
  logic                under;
  logic [LEN_W-1:0]    eff_len;
  logic [HOLD_W:0]     hcnt_inc;

  state_t              state, state_n;
  logic [LEN_W-1:0]    cnt, cnt_n;
  logic [HOLD_W-1:0]   hcnt, hcnt_n;
  logic signed [W-1:0] peak, peak_n, peak_upd;
  logic                start_n, end_n;

  logic signed [W-1:0] dout_p1;
  logic signed [W-1:0] peak_out_p1;
  logic                vld_p1, sat_p1, start_p1, end_p1;

  // Magnitude as unsigned W bits; the most negative value maps to 2^(W-1).
  function automatic logic [W-1:0] abs_mag(input logic signed [W-1:0] v);
    logic [W-1:0] u;
    u = v;
    return u[W-1] ? (~u + W'(1)) : u;
  endfunction

  // ---- stage p0: combinational correction and classification ----
  sat_sub #(.W(W)) u_sat_sub (
    .a   (bus.din),
    .b   (bus.drift_in),
    .y   (corr),
    .sat (corr_sat)
  );

  // Classify the corrected sample against the live thresholds.
  always_comb begin
    mag      = abs_mag(corr);
    pk_mag   = abs_mag(peak);
    over     = (mag > trig_th);
    under    = (mag < rel_th);
    eff_len  = (min_len == '0) ? LEN_W'(1) : min_len;
    hcnt_inc = {1'b0, hcnt} + (HOLD_W+1)'(1);
    peak_upd = (mag > pk_mag) ? corr : peak;
  end

  // Next-state logic; nothing moves unless the sample is strobed.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hcnt_n  = hcnt;
    peak_n  = peak;
    start_n = 1'b0;
    end_n   = 1'b0;
    if (bus.din_valid) begin
      unique case (state)
        IDLE: begin
          if (over) begin
            cnt_n  = LEN_W'(1);
            peak_n = corr;
            if (eff_len == LEN_W'(1)) begin
              state_n = EVENT;
              start_n = 1'b1;
            end else begin
              state_n = CAND;
            end
          end
        end
        CAND: begin
          if (over) begin
            peak_n = peak_upd;
            if (cnt >= eff_len - LEN_W'(1)) begin
              cnt_n   = eff_len;
              state_n = EVENT;
              start_n = 1'b1;
            end else begin
              cnt_n = cnt + LEN_W'(1);
            end
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        EVENT: begin
          peak_n = peak_upd;
          if (under) begin
            end_n  = 1'b1;
            cnt_n  = '0;
            hcnt_n = '0;
            state_n = (holdoff == '0) ? IDLE : HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (hcnt_inc >= {1'b0, holdoff}) begin
            hcnt_n  = holdoff;
            state_n = IDLE;
          end else begin
            hcnt_n = hcnt_inc[HOLD_W-1:0];
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // ---- stage p1: FSM state, counters and peak ----
  // Qualifier state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hcnt  <= '0;
      peak  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hcnt  <= hcnt_n;
      peak  <= peak_n;
    end
  end

  // Registered corrected sample, flags, pulses and captured peak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_p1     <= '0;
      sat_p1      <= 1'b0;
      vld_p1      <= 1'b0;
      start_p1    <= 1'b0;
      end_p1      <= 1'b0;
      peak_out_p1 <= '0;
    end else begin
      vld_p1   <= bus.din_valid;
      start_p1 <= start_n;
      end_p1   <= end_n;
      if (bus.din_valid) begin
        dout_p1 <= corr;
        sat_p1  <= corr_sat;
      end
      if (end_n) begin
        peak_out_p1 <= peak_upd;
      end
    end
  end

  assign bus.dout         = dout_p1;
  assign bus.dout_valid   = vld_p1;
  assign bus.sat_flag     = sat_p1;
  assign bus.event_start  = start_p1;
  assign bus.event_end    = end_p1;
  assign bus.peak_out     = peak_out_p1;
  assign bus.event_active = (state == EVENT);
  assign bus.freeze_req   = (state != IDLE);

endmodule

// File: tb/tb_drift_comp_detect.sv
// Bench for drift_comp_detect: directed scenarios plus randomized traffic,
// all checked against an arithmetic reference model of the event rules.
module tb_drift_comp_detect;

  localparam int W      = 24;
  localparam int LEN_W  = 8;
  localparam int HOLD_W = 16;
  localparam int VW     = 2*W + 6;
  localparam longint SMAX = (longint'(1) <<< (W-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W-1));
  localparam int M_IDLE = 0, M_CAND = 1, M_EVENT = 2, M_HOLD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [W-1:0]      trig_th = '0;
  logic [W-1:0]      rel_th  = '0;
  logic [LEN_W-1:0]  min_len = '0;
  logic [HOLD_W-1:0] holdoff = '0;

  drift_comp_detect_if #(.W(W)) bus ();

  drift_comp_detect #(.W(W), .LEN_W(LEN_W), .HOLD_W(HOLD_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .trig_th (trig_th),
    .rel_th  (rel_th),
    .min_len (min_len),
    .holdoff (holdoff)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state and expected outputs.
  int     m_state, m_cnt, m_hcnt;
  longint m_peak;
  logic signed [W-1:0] e_dout, e_peak;
  logic e_vld, e_sat, e_act, e_start, e_end, e_frz;

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.dout, bus.dout_valid, bus.sat_flag, bus.event_active,
            bus.event_start, bus.event_end, bus.peak_out, bus.freeze_req};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_dout, e_vld, e_sat, e_act, e_start, e_end, e_peak, e_frz};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_cnt = 0; m_hcnt = 0; m_peak = 0;
    e_dout = '0; e_peak = '0;
    e_vld = 0; e_sat = 0; e_act = 0; e_start = 0; e_end = 0; e_frz = 0;
  endtask

  task automatic model_step(input logic signed [W-1:0] d,
                            input logic signed [W-1:0] b, input bit v);
    longint diff, c, mg, trig, rel;
    int eff, hold;
    e_start = 0; e_end = 0; e_vld = v;
    if (v) begin
      diff = longint'(d) - longint'(b);
      if (diff > SMAX)      begin c = SMAX; e_sat = 1; end
      else if (diff < SMIN) begin c = SMIN; e_sat = 1; end
      else                  begin c = diff; e_sat = 0; end
      e_dout = c[W-1:0];
      mg   = labs(c);
      trig = longint'(trig_th);
      rel  = longint'(rel_th);
      eff  = (min_len == 0) ? 1 : int'(min_len);
      hold = int'(holdoff);
      case (m_state)
        M_IDLE: if (mg > trig) begin
          m_peak = c; m_cnt = 1;
          if (eff == 1) begin m_state = M_EVENT; e_start = 1; end
          else m_state = M_CAND;
        end
        M_CAND: if (mg > trig) begin
          m_cnt++;
          if (mg > labs(m_peak)) m_peak = c;
          if (m_cnt >= eff) begin m_state = M_EVENT; e_start = 1; end
        end else begin
          m_state = M_IDLE; m_cnt = 0;
        end
        M_EVENT: begin
          if (mg > labs(m_peak)) m_peak = c;
          if (mg < rel) begin
            e_end = 1; e_peak = m_peak[W-1:0]; m_cnt = 0; m_hcnt = 0;
            m_state = (hold == 0) ? M_IDLE : M_HOLD;
          end
        end
        default: begin
          m_hcnt++;
          if (m_hcnt >= hold) m_state = M_IDLE;
        end
      endcase
    end
    e_act = (m_state == M_EVENT);
    e_frz = (m_state != M_IDLE);
  endtask

  // One clock with the given raw inputs; model follows the same edge.
  task automatic send_raw(input logic signed [W-1:0] d,
                          input logic signed [W-1:0] b, input bit v);
    bus.din = d; bus.drift_in = b; bus.din_valid = v;
    @(posedge clk); #1;
    model_step(d, b, v);
    bus.din_valid = 1'b0;
  endtask

  // Sample with a given corrected value on top of a random baseline.
  task automatic send_corr(input int corr, input bit v);
    int b;
    b = int'($urandom_range(0, 4000)) - 2000;
    send_raw(W'(corr + b), W'(b), v);
  endtask

  task automatic set_cfg(input int tr, input int rl, input int ml, input int ho);
    trig_th = W'(tr); rel_th = W'(rl); min_len = LEN_W'(ml); holdoff = HOLD_W'(ho);
  endtask

  task automatic test_reset();
    bus.din = '0; bus.drift_in = '0; bus.din_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", obs_vec(), exp_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    set_cfg(1000, 500, 3, 2);
    send_raw(W'(1000), W'(400), 1'b1);
    vectors++;
    if (obs_vec() !== exp_vec() || bus.dout !== W'(600) || bus.dout_valid !== 1'b1
        || bus.sat_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL passthrough: got dout=%0d vld=%b sat=%b, want 600 1 0",
               bus.dout, bus.dout_valid, bus.sat_flag);
    end
    send_raw(W'(1000), W'(400), 1'b0);
    vectors++;
    if (obs_vec() !== exp_vec() || bus.dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL passthrough_gap: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_saturation();
    logic signed [W-1:0] dv [4];
    logic signed [W-1:0] bv [4];
    logic [W-1:0]        want [4];
    logic                wsat [4];
    set_cfg(24'hFFFFFF, 0, 3, 0);
    dv[0] = 24'h7FFFFF; bv[0] = -24'sd10; want[0] = 24'h7FFFFF; wsat[0] = 1;
    dv[1] = 24'h800000; bv[1] = 24'sd5;   want[1] = 24'h800000; wsat[1] = 1;
    dv[2] = 24'h7FFFFF; bv[2] = 24'sd0;   want[2] = 24'h7FFFFF; wsat[2] = 0;
    dv[3] = 24'h800000; bv[3] = 24'sd0;   want[3] = 24'h800000; wsat[3] = 0;
    for (int i = 0; i < 4; i++) begin
      send_raw(dv[i], bv[i], 1'b1);
      vectors++;
      if (obs_vec() !== exp_vec() || bus.dout !== want[i] || bus.sat_flag !== wsat[i]) begin
        miscompares++;
        $display("FAIL saturation[%0d]: got dout=%h sat=%b, want %h %b",
                 i, bus.dout, bus.sat_flag, want[i], wsat[i]);
      end
    end
  endtask

  task automatic test_event();
    int seq [10] = '{150, 160, 170, -300, 40, 200, 200, 200, 0, 0};
    set_cfg(100, 50, 3, 2);
    for (int i = 0; i < 10; i++) begin
      send_corr(seq[i], 1'b1);
      vectors++;
      if (obs_vec() !== exp_vec()
          || (i == 2 && (bus.event_start !== 1'b1 || bus.event_active !== 1'b1))
          || (i == 4 && (bus.event_end !== 1'b1 || bus.peak_out !== -24'sd300))
          || (i == 5 && (bus.freeze_req !== 1'b1 || bus.event_active !== 1'b0))) begin
        miscompares++;
        $display("FAIL event[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    int seq [3] = '{150, 150, 20};
    set_cfg(100, 50, 3, 2);
    for (int i = 0; i < 3; i++) begin
      send_corr(seq[i], 1'b1);
      vectors++;
      if (obs_vec() !== exp_vec() || bus.event_start !== 1'b0
          || (i == 2 && bus.freeze_req !== 1'b0)) begin
        miscompares++;
        $display("FAIL glitch[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_valid_gaps();
    int seq [8] = '{150, 160, 170, -300, 40, 200, 200, 200};
    int starts = 0, ends = 0;
    set_cfg(100, 50, 3, 2);
    for (int i = 0; i < 8; i++) begin
      send_corr(seq[i], 1'b1);
      starts += int'(bus.event_start); ends += int'(bus.event_end);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL gaps_valid[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      for (int g = 0; g < 5; g++) begin
        send_corr(seq[i], 1'b0);
        starts += int'(bus.event_start); ends += int'(bus.event_end);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL gaps_idle[%0d.%0d]: got %h want %h", i, g, obs_vec(), exp_vec());
        end
      end
    end
    vectors++;
    if (starts != 1 || ends != 1) begin
      miscompares++;
      $display("FAIL gaps_pulses: got starts=%0d ends=%0d, want 1 1", starts, ends);
    end
    send_corr(0, 1'b1);
  endtask

  task automatic test_reset_mid_event();
    int seq [3] = '{150, 160, 170};
    set_cfg(100, 50, 3, 2);
    for (int i = 0; i < 3; i++) send_corr(seq[i], 1'b1);
    vectors++;
    if (obs_vec() !== exp_vec() || bus.event_active !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre: got %h want %h", obs_vec(), exp_vec());
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs_vec() !== exp_vec() || bus.event_end !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: got %h want %h", obs_vec(), exp_vec());
    end
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_corr(seq[i], 1'b1);
      vectors++;
      if (obs_vec() !== exp_vec() || bus.event_start !== (i == 2)) begin
        miscompares++;
        $display("FAIL midrst_after[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int corr;
    bit v;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0)
        set_cfg(int'($urandom_range(0, 200)), int'($urandom_range(0, 200)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      v = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 19) == 0) begin
        send_raw(W'($urandom), W'($urandom), v);
      end else begin
        corr = int'($urandom_range(0, 600)) - 300;
        send_corr(corr, v);
      end
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h want %h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_passthrough();
    test_saturation();
    test_event();
    test_glitch();
    test_valid_gaps();
    test_reset_mid_event();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
